// File: rtl/db_reg_bank_if.sv
// rtl/db_reg_bank_if.sv - DATA_BUS slave/master bus interface
interface DATA_BUS;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] conf_base_addr;
    logic [31:0] conf_addr_mask;

    modport Master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err, conf_base_addr, conf_addr_mask
    );

    modport Slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err, conf_base_addr, conf_addr_mask
    );
endinterface

// File: rtl/db_reg_bank.sv
// rtl/db_reg_bank.sv - DATA_BUS slave register bank with per-word access modes
module db_reg_bank #(
    parameter int                        N_WORDS   = 1,
    parameter logic [31:0]               base_addr = 32'h1 << $clog2(N_WORDS),
    parameter logic [31:0]               addr_mask = base_addr - 32'h1,
    parameter logic [N_WORDS-1:0][31:0]  REG_INIT  = '0,
    parameter logic [N_WORDS-1:0][1:0]   REG_MODE  = '0,
    parameter logic [N_WORDS-1:0]        IRQ_MASK  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N_WORDS-1:0][31:0]    reg_data_o,
    input  logic [N_WORDS-1:0][31:0]    upd_data_i,
    input  logic [N_WORDS-1:0]          upd_valid_i,
    output logic [N_WORDS-1:0]          rd_strobe_o,
    output logic [N_WORDS-1:0]          wr_strobe_o,
    output logic [N_WORDS-1:0]          fresh_o,
    output logic [N_WORDS-1:0]          overrun_o,
    output logic                        irq_o,
    DATA_BUS.Slave                      dslv
);
    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;
    localparam logic [1:0] MODE_RC  = 2'd3;

    logic [N_WORDS-1:0][31:0] reg_q, reg_d;
    logic [N_WORDS-1:0]       fresh_q, fresh_d;
    logic [N_WORDS-1:0]       ovr_q, ovr_d;
    logic [N_WORDS-1:0]       rd_hit, wr_hit, wr_stb_d;
    logic [31:0]              local_addr, word_idx, bemask, wmask, rd_word;
    logic                     in_range, rd_acc, wr_acc;
    logic                     rvalid_q, err_q, irq_q;
    logic [31:0]              rdata_q;
    logic [N_WORDS-1:0]       rd_stb_q, wr_stb_q;

    assign dslv.gnt            = dslv.req;
    assign dslv.conf_base_addr = base_addr;
    assign dslv.conf_addr_mask = addr_mask;
    assign dslv.rvalid         = rvalid_q;
    assign dslv.rdata          = rdata_q;
    assign dslv.err            = err_q;
    assign reg_data_o          = reg_q;
    assign rd_strobe_o         = rd_stb_q;
    assign wr_strobe_o         = wr_stb_q;
    assign fresh_o             = fresh_q;
    assign overrun_o           = ovr_q;
    assign irq_o               = irq_q;

    always_comb begin
        local_addr = dslv.addr & addr_mask;
        word_idx   = local_addr >> 2;
        in_range   = (word_idx < 32'(N_WORDS));
        rd_acc     = dslv.req & ~dslv.we & in_range;
        wr_acc     = dslv.req &  dslv.we & in_range;
        bemask     = {{8{dslv.be[3]}}, {8{dslv.be[2]}}, {8{dslv.be[1]}}, {8{dslv.be[0]}}};
        wmask      = dslv.wdata & bemask;
        rd_word    = '0;
        rd_hit     = '0;
        wr_hit     = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (word_idx == 32'(k)) begin
                rd_word   = reg_q[k];
                rd_hit[k] = rd_acc;
                wr_hit[k] = wr_acc;
            end
        end
    end

    // Peripheral updates take priority over bus writes, except W1C where both merge bitwise.
    always_comb begin
        reg_d    = reg_q;
        fresh_d  = fresh_q;
        ovr_d    = ovr_q;
        wr_stb_d = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            case (REG_MODE[k])
                MODE_RW, MODE_RC: begin
                    if (upd_valid_i[k]) begin
                        reg_d[k] = upd_data_i[k];
                    end else if (wr_hit[k]) begin
                        reg_d[k]    = (reg_q[k] & ~bemask) | (dslv.wdata & bemask);
                        wr_stb_d[k] = 1'b1;
                    end else if (rd_hit[k] && (REG_MODE[k] == MODE_RC)) begin
                        reg_d[k] = '0;
                    end
                end
                MODE_RO: begin
                    if (upd_valid_i[k]) begin
                        reg_d[k] = upd_data_i[k];
                    end
                end
                MODE_W1C: begin
                    reg_d[k] = (reg_q[k] & ~(wr_hit[k] ? wmask : 32'h0))
                             | (upd_valid_i[k] ? upd_data_i[k] : 32'h0);
                    wr_stb_d[k] = wr_hit[k];
                end
                default: reg_d[k] = reg_q[k];
            endcase
            if (upd_valid_i[k]) begin
                fresh_d[k] = 1'b1;
            end else if (rd_hit[k]) begin
                fresh_d[k] = 1'b0;
            end
            ovr_d[k] = (ovr_q[k] & ~wr_hit[k]) | (upd_valid_i[k] & fresh_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q    <= REG_INIT;
            fresh_q  <= '0;
            ovr_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rd_stb_q <= '0;
            wr_stb_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            reg_q    <= reg_d;
            fresh_q  <= fresh_d;
            ovr_q    <= ovr_d;
            rvalid_q <= dslv.req;
            err_q    <= dslv.req & ~in_range;
            rdata_q  <= rd_acc ? rd_word : 32'h0;
            rd_stb_q <= rd_hit;
            wr_stb_q <= wr_stb_d;
            irq_q    <= |(fresh_q & IRQ_MASK);
        end
    end
endmodule

// File: tb/tb_db_reg_bank.sv
// tb/tb_db_reg_bank.sv - self-checking bench for db_reg_bank
module tb_db_reg_bank;
    localparam int N = 6;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] MASK = 32'h0000_00FF;
    localparam logic [N-1:0][31:0] INIT = {32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'hA5A5_0001, 32'h0};
    // word: 5 W1C, 4 RW, 3 RC, 2 W1C, 1 RO, 0 RW
    localparam logic [N-1:0][1:0] MODES = {2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [N-1:0] IRQ = 6'b011000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    DATA_BUS bus();
    logic [N-1:0][31:0] reg_data, upd_data;
    logic [N-1:0]       upd_valid, rd_strobe, wr_strobe, fresh, overrun;
    logic               irq;

    db_reg_bank #(
        .N_WORDS(N), .base_addr(BASE), .addr_mask(MASK),
        .REG_INIT(INIT), .REG_MODE(MODES), .IRQ_MASK(IRQ)
    ) dut (
        .clk(clk), .rst(rst), .reg_data_o(reg_data), .upd_data_i(upd_data),
        .upd_valid_i(upd_valid), .rd_strobe_o(rd_strobe), .wr_strobe_o(wr_strobe),
        .fresh_o(fresh), .overrun_o(overrun), .irq_o(irq), .dslv(bus)
    );

    int checks = 0;
    int failures = 0;

    logic [N-1:0][31:0] m_reg;
    logic [N-1:0]       m_fresh, m_ovr, e_rd, e_wr;
    logic               e_rvalid, e_err, e_irq;
    logic [31:0]        e_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = '0; bus.wdata = '0;
        upd_valid = '0; upd_data = '0;
    endtask

    task automatic drive_rd(input int w);
        bus.req = 1'b1; bus.we = 1'b0; bus.be = 4'hF; bus.addr = BASE + 32'(w * 4); bus.wdata = '0;
    endtask

    task automatic drive_wr(input int w, input logic [31:0] d, input logic [3:0] be);
        bus.req = 1'b1; bus.we = 1'b1; bus.be = be; bus.addr = BASE + 32'(w * 4); bus.wdata = d;
    endtask

    // One clock: predict from the access rules, advance, then compare every output.
    task automatic step();
        logic [31:0] la, bm, wm;
        int unsigned idx;
        bit inr, rd, wr, upd;
        logic [N-1:0][31:0] n_reg;
        logic [N-1:0] n_fresh, n_ovr;
        #1;
        chk("gnt", 32'(bus.gnt), 32'(bus.req));
        n_reg = m_reg; n_fresh = m_fresh; n_ovr = m_ovr;
        e_rd = '0; e_wr = '0;
        if (rst) begin
            n_reg = INIT; n_fresh = '0; n_ovr = '0;
            e_rvalid = 0; e_err = 0; e_rdata = 0; e_irq = 0;
        end else begin
            la  = bus.addr & MASK;
            idx = la >> 2;
            inr = (idx < N);
            e_rvalid = bus.req;
            e_err    = bus.req && !inr;
            e_rdata  = 0;
            if (bus.req && !bus.we && inr) e_rdata = m_reg[idx];
            e_irq = |(m_fresh & IRQ);
            bm = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
            wm = bus.wdata & bm;
            for (int k = 0; k < N; k++) begin
                rd  = bus.req && !bus.we && inr && (idx == k);
                wr  = bus.req &&  bus.we && inr && (idx == k);
                upd = upd_valid[k];
                e_rd[k] = rd;
                if (MODES[k] == 2'd2) begin
                    n_reg[k] = (m_reg[k] & ~(wr ? wm : 32'h0)) | (upd ? upd_data[k] : 32'h0);
                    e_wr[k]  = wr;
                end else if (upd) begin
                    n_reg[k] = upd_data[k];
                end else if (wr && MODES[k] != 2'd1) begin
                    n_reg[k] = (m_reg[k] & ~bm) | (bus.wdata & bm);
                    e_wr[k]  = 1;
                end else if (rd && MODES[k] == 2'd3) begin
                    n_reg[k] = 0;
                end
                if (upd) n_fresh[k] = 1;
                else if (rd) n_fresh[k] = 0;
                if (upd && m_fresh[k]) n_ovr[k] = 1;
                else if (wr) n_ovr[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        m_reg = n_reg; m_fresh = n_fresh; m_ovr = n_ovr;
        chk("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
        chk("err", 32'(bus.err), 32'(e_err));
        chk("rdata", bus.rdata, e_rdata);
        chk("rd_strobe", 32'(rd_strobe), 32'(e_rd));
        chk("wr_strobe", 32'(wr_strobe), 32'(e_wr));
        chk("fresh", 32'(fresh), 32'(m_fresh));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("irq", 32'(irq), 32'(e_irq));
        for (int k = 0; k < N; k++) chk($sformatf("reg%0d", k), reg_data[k], m_reg[k]);
    endtask

    initial begin
        m_reg = INIT; m_fresh = '0; m_ovr = '0;
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("conf_base", bus.conf_base_addr, 32'h0000_0100);
        chk("conf_mask", bus.conf_addr_mask, 32'h0000_00FF);
        chk("reset_reg1", reg_data[1], 32'hA5A5_0001);
        chk("reset_rvalid", 32'(bus.rvalid), 32'h0);

        // reset value readback
        drive_rd(1); step(); idle_in();
        chk("t1_rdata", bus.rdata, 32'hA5A5_0001);
        chk("t1_rvalid", 32'(bus.rvalid), 32'h1);
        step();

        // byte-enabled RW write
        drive_wr(0, 32'h1234_5678, 4'b0011); step(); idle_in();
        chk("t2_wr_strobe", 32'(wr_strobe[0]), 32'h1);
        drive_rd(0); step(); idle_in();
        chk("t2_rdata", bus.rdata, 32'h0000_5678);
        chk("t2_wr_strobe_once", 32'(wr_strobe[0]), 32'h0);

        // W1C clear racing a set
        drive_wr(2, 32'h0000_000F, 4'hF);
        upd_valid[2] = 1'b1; upd_data[2] = 32'h0000_0001;
        step(); idle_in();
        chk("t3_reg2", reg_data[2], 32'h0000_00F1);

        // RC with fresh and irq
        upd_valid[3] = 1'b1; upd_data[3] = 32'h0000_CAFE; step(); idle_in();
        chk("t4_fresh", 32'(fresh[3]), 32'h1);
        step();
        chk("t4_irq", 32'(irq), 32'h1);
        drive_rd(3); step(); idle_in();
        chk("t4_rdata", bus.rdata, 32'h0000_CAFE);
        chk("t4_cleared", reg_data[3], 32'h0);
        step();
        chk("t4_irq_fall", 32'(irq), 32'h0);

        // overrun
        upd_valid[3] = 1'b1; upd_data[3] = 32'h0000_0011; step();
        upd_data[3] = 32'h0000_0022; step(); idle_in();
        chk("t5_overrun", 32'(overrun[3]), 32'h1);
        drive_rd(3); step(); idle_in();
        chk("t5_overrun_after_rd", 32'(overrun[3]), 32'h1);
        drive_wr(3, 32'h0000_0005, 4'hF); step(); idle_in();
        chk("t5_overrun_clr", 32'(overrun[3]), 32'h0);

        // out of range, then reset with a pending read
        drive_rd(N); step(); idle_in();
        chk("t6_err", 32'(bus.err), 32'h1);
        chk("t6_rdata", bus.rdata, 32'h0);
        drive_wr(N, 32'hFFFF_FFFF, 4'hF); step(); idle_in();
        chk("t6_wr_strobe", 32'(wr_strobe), 32'h0);
        drive_rd(1); rst = 1'b1; step(); rst = 1'b0; idle_in();
        chk("t6_rst_rvalid", 32'(bus.rvalid), 32'h0);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            bus.req   = $urandom_range(0, 1);
            bus.we    = $urandom_range(0, 1);
            bus.be    = 4'($urandom);
            bus.addr  = BASE + 32'($urandom_range(0, 7) * 4);
            bus.wdata = $urandom;
            for (int k = 0; k < N; k++) begin
                upd_valid[k] = ($urandom_range(0, 3) == 0);
                upd_data[k]  = $urandom;
            end
            step();
        end
        rst = 1'b0;
        idle_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
